// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two pipeline stages and the buffer between them.
// slave  : the buffer side (pipe_stage_buf).
// master : the side that drives upstream payload and downstream ready/flush.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 64
);
  logic              up_valid_i;
  logic [DATA_W-1:0] up_data_i;
  logic              up_ready_o;
  logic              dn_valid_o;
  logic [DATA_W-1:0] dn_data_o;
  logic              dn_ready_i;
  logic              flush_i;
  logic [1:0]        occ_o;

  modport slave (
    input  up_valid_i, up_data_i, dn_ready_i, flush_i,
    output up_ready_o, dn_valid_o, dn_data_o, occ_o
  );

  modport master (
    output up_valid_i, up_data_i, dn_ready_i, flush_i,
    input  up_ready_o, dn_valid_o, dn_data_o, occ_o
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush and bubble insertion.
// Optional macro PIPE_STAGE_PERF_EN adds stall/transfer counters.
// All outputs come straight from flops: there is no combinational path from
// dn_ready_i to up_ready_o or dn_valid_o.
module pipe_stage_buf #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            xfer_cnt_o,
`endif
  pipe_stage_buf_if.slave        bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready_q;
  logic              dn_valid_q;
  logic [1:0]        occ_q;

  logic up_fire;
  logic dn_fire;

  // up_ready_q is already low in FULL, so up_valid_i is ignored there.
  assign up_fire = bus.up_valid_i & up_ready_q;
  assign dn_fire = dn_valid_q & bus.dn_ready_i;

  assign bus.up_ready_o = up_ready_q;
  assign bus.dn_valid_o = dn_valid_q;
  assign bus.dn_data_o  = main_q;
  assign bus.occ_o      = occ_q;

  // Next-state and storage update; flush dominates every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_fire) begin
            state_d = ONE;
            main_d  = bus.up_data_i;
          end else begin
            main_d  = BUBBLE_VAL;
          end
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            main_d  = bus.up_data_i;
          end else if (up_fire) begin
            state_d = FULL;
            skid_d  = bus.up_data_i;
          end else if (dn_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        FULL: begin
          if (dn_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= (state_d != FULL);
      dn_valid_q <= (state_d != EMPTY);
      occ_q      <= state_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] xfer_cnt_q;

  assign stall_cnt_o = stall_cnt_q;
  assign xfer_cnt_o  = xfer_cnt_q;

  // Performance counters survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      if (dn_valid_q && !bus.dn_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (dn_fire)                       xfer_cnt_q  <= xfer_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenario tasks plus a
// scoreboard that follows every accepted payload to the downstream port.
module tb_pipe_stage_buf;
  localparam int DW = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  int tests  = 0;
  int errors = 0;

  logic [DW-1:0] sb_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] xfer_cnt_o;
`endif

  pipe_stage_buf_if #(.DATA_W(DW)) bus ();

  pipe_stage_buf #(.DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt_o (stall_cnt_o),
    .xfer_cnt_o  (xfer_cnt_o),
`endif
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: at the falling edge the values seen by the next rising edge
  // are stable, so pop on downstream transfer, then clear on flush or push
  // on upstream transfer (an entry accepted this cycle queues behind).
  always @(negedge clk_i) begin
    if (!rst_i) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (bus.dn_data_o !== prev_data) begin
          errors++;
          $display("FAIL stability: dn_data_o=%h required %h", bus.dn_data_o, prev_data);
        end
      end
      if (bus.dn_valid_o && bus.dn_ready_i) begin
        tests++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: dn_data_o=%h emitted, nothing expected", bus.dn_data_o);
        end else begin
          logic [DW-1:0] exp;
          exp = sb_q.pop_front();
          if (bus.dn_data_o !== exp) begin
            errors++;
            $display("FAIL sb_data: dn_data_o=%h required %h", bus.dn_data_o, exp);
          end
        end
      end
      if (bus.flush_i) sb_q.delete();
      else if (bus.up_valid_i && bus.up_ready_o) sb_q.push_back(bus.up_data_i);
      prev_stall = bus.dn_valid_o && !bus.dn_ready_i && !bus.flush_i;
      prev_data  = bus.dn_data_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.up_valid_i = 1'b0;
    bus.up_data_i  = '0;
    bus.dn_ready_i = 1'b0;
    bus.flush_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    bus.up_valid_i = 1'b1;
    bus.up_data_i  = 16'h1234;
    bus.dn_ready_i = 1'b0;
    bus.flush_i    = 1'b0;
    step();
    step();
    tests++;
    if (bus.dn_valid_o !== 1'b0 || bus.dn_data_o !== 16'h0 ||
        bus.up_ready_o !== 1'b1 || bus.occ_o !== 2'd0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h ready=%b occ=%0d required 0/0000/1/0",
               bus.dn_valid_o, bus.dn_data_o, bus.up_ready_o, bus.occ_o);
    end
    idle();
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_stream();
    bus.dn_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.up_valid_i = 1'b1;
      bus.up_data_i  = 16'h10 + 16'(i);
      step();
      tests++;
      if (bus.dn_valid_o !== 1'b1 || bus.dn_data_o !== 16'h10 + 16'(i) ||
          bus.occ_o !== 2'd1 || bus.up_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b data=%h occ=%0d ready=%b required 1/%h/1/1",
                 i, bus.dn_valid_o, bus.dn_data_o, bus.occ_o, bus.up_ready_o, 16'h10 + 16'(i));
      end
    end
    bus.up_valid_i = 1'b0;
    step();
    idle();
  endtask

  task automatic test_backpressure();
    bus.dn_ready_i = 1'b0;
    bus.up_valid_i = 1'b1;
    bus.up_data_i  = 16'hA0;
    step();
    bus.up_data_i  = 16'hA1;
    step();
    tests++;
    if (bus.occ_o !== 2'd2 || bus.up_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: occ=%0d ready=%b required 2/0", bus.occ_o, bus.up_ready_o);
    end
    bus.up_data_i  = 16'hA2;
    step();
    tests++;
    if (bus.occ_o !== 2'd2 || bus.dn_data_o !== 16'hA0 || bus.up_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: occ=%0d data=%h ready=%b required 2/00a0/0",
               bus.occ_o, bus.dn_data_o, bus.up_ready_o);
    end
    bus.dn_ready_i = 1'b1;
    step();
    tests++;
    if (bus.dn_data_o !== 16'hA1 || bus.occ_o !== 2'd1 || bus.up_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1: data=%h occ=%0d ready=%b required 00a1/1/1",
               bus.dn_data_o, bus.occ_o, bus.up_ready_o);
    end
    step();
    tests++;
    if (bus.dn_data_o !== 16'hA2 || bus.occ_o !== 2'd1) begin
      errors++;
      $display("FAIL bp_drain2: data=%h occ=%0d required 00a2/1", bus.dn_data_o, bus.occ_o);
    end
    bus.up_valid_i = 1'b0;
    step();
    tests++;
    if (bus.occ_o !== 2'd0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_empty: occ=%0d pending=%0d required 0/0", bus.occ_o, sb_q.size());
    end
    idle();
  endtask

  task automatic test_flush();
    bus.dn_ready_i = 1'b0;
    bus.up_valid_i = 1'b1;
    bus.up_data_i  = 16'hB0;
    step();
    bus.up_data_i  = 16'hB1;
    step();
    bus.up_data_i  = 16'hB2;
    bus.flush_i    = 1'b1;
    step();
    tests++;
    if (bus.occ_o !== 2'd0 || bus.dn_valid_o !== 1'b0 || bus.dn_data_o !== 16'h0 ||
        bus.up_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush: occ=%0d valid=%b data=%h ready=%b required 0/0/0000/1",
               bus.occ_o, bus.dn_valid_o, bus.dn_data_o, bus.up_ready_o);
    end
    // Flush while ONE with an accepted push: the push is dropped too.
    bus.flush_i = 1'b0;
    bus.up_data_i = 16'hB3;
    step();
    bus.up_data_i = 16'hB4;
    bus.flush_i   = 1'b1;
    step();
    bus.flush_i    = 1'b0;
    bus.up_valid_i = 1'b0;
    bus.dn_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.dn_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak[%0d]: dn_valid_o=%b data=%h required 0",
                 i, bus.dn_valid_o, bus.dn_data_o);
      end
    end
    idle();
  endtask

  task automatic test_drain_bubble();
    bus.up_valid_i = 1'b1;
    bus.up_data_i  = 16'hC0;
    step();
    tests++;
    if (bus.dn_valid_o !== 1'b1 || bus.dn_data_o !== 16'hC0 || bus.occ_o !== 2'd1) begin
      errors++;
      $display("FAIL drain_one: valid=%b data=%h occ=%0d required 1/00c0/1",
               bus.dn_valid_o, bus.dn_data_o, bus.occ_o);
    end
    bus.up_valid_i = 1'b0;
    bus.up_data_i  = 'x;
    bus.dn_ready_i = 1'b1;
    step();
    tests++;
    if (bus.dn_valid_o !== 1'b0 || bus.dn_data_o !== 16'h0 || bus.occ_o !== 2'd0) begin
      errors++;
      $display("FAIL drain_bubble: valid=%b data=%h occ=%0d required 0/0000/0",
               bus.dn_valid_o, bus.dn_data_o, bus.occ_o);
    end
    step();
    tests++;
    if (bus.dn_data_o !== 16'h0) begin
      errors++;
      $display("FAIL x_block: data=%h required 0000", bus.dn_data_o);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int budget;
    for (int i = 0; i < 300; i++) begin
      bus.up_valid_i = 1'($urandom_range(0, 3) != 0);
      bus.up_data_i  = 16'($urandom);
      bus.dn_ready_i = 1'($urandom_range(0, 2) != 0);
      bus.flush_i    = 1'($urandom_range(0, 40) == 0);
      step();
    end
    bus.up_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    bus.dn_ready_i = 1'b1;
    budget = 0;
    while ((sb_q.size() != 0 || bus.dn_valid_o) && budget < 10) begin
      step();
      budget++;
    end
    tests++;
    if (sb_q.size() != 0 || bus.dn_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: pending=%0d valid=%b required 0/0 within 10 cycles",
               sb_q.size(), bus.dn_valid_o);
    end
    idle();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    idle();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    bus.up_valid_i = 1'b1;
    bus.up_data_i  = 16'hD0;
    step();
    bus.up_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    bus.dn_ready_i = 1'b1;
    bus.up_valid_i = 1'b1;
    bus.up_data_i  = 16'hD1;
    step();
    bus.up_data_i  = 16'hD2;
    step();
    bus.up_valid_i = 1'b0;
    step();
    bus.dn_ready_i = 1'b0;
    tests++;
    if (stall_cnt_o !== 32'd5 || xfer_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL perf_cnt: stall=%0d xfer=%0d required 5/3", stall_cnt_o, xfer_cnt_o);
    end
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    tests++;
    if (stall_cnt_o !== 32'd5 || xfer_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL perf_flush: stall=%0d xfer=%0d required 5/3", stall_cnt_o, xfer_cnt_o);
    end
    idle();
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_drain_bubble();
    test_back_to_back();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    step();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
